// File: rtl/alu_rot_pkg.sv
// Shared mode encodings for the ALU shift/rotate pipeline.
package alu_rot_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_ROL = 3'd0;
  localparam logic [MODE_W-1:0] MODE_ROR = 3'd1;
  localparam logic [MODE_W-1:0] MODE_SHL = 3'd2;
  localparam logic [MODE_W-1:0] MODE_SHR = 3'd3;
  localparam logic [MODE_W-1:0] MODE_SAR = 3'd4;

  function automatic logic mode_is_legal(input logic [MODE_W-1:0] mode);
    return mode <= MODE_SAR;
  endfunction

endpackage

// File: rtl/rot_barrel_core.sv
// Combinational barrel shifter/rotator: one mux stage per amount bit,
// plus the carry (last bit moved across the word boundary) and illegal flag.
module rot_barrel_core
  import alu_rot_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]  data_i,
  input  logic [AMT_W-1:0]  amt_i,
  input  logic [MODE_W-1:0] mode_i,
  output logic [WIDTH-1:0]  res_o,
  output logic              carry_o,
  output logic              illegal_o
);

  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0] res;
  logic [AMT_W-1:0] neg_amt;
  logic [AMT_W-1:0] dec_amt;
  logic             sign;

  always_comb begin
    res     = data_i;
    sign    = data_i[WIDTH-1];
    // WIDTH is a power of two, so -amt wraps to WIDTH-amt for amt in 1..WIDTH-1
    neg_amt = AMT_W'(0) - amt_i;
    dec_amt = amt_i - AMT_W'(1);
    for (int k = 0; k < AMT_W; k++) begin
      if (amt_i[k]) begin
        case (mode_i)
          MODE_ROL: res = (res << (1 << k)) | (res >> (WIDTH - (1 << k)));
          MODE_ROR: res = (res >> (1 << k)) | (res << (WIDTH - (1 << k)));
          MODE_SHL: res = res << (1 << k);
          MODE_SHR: res = res >> (1 << k);
          MODE_SAR: res = (res >> (1 << k)) | (~(ONES >> (1 << k)) & {WIDTH{sign}});
          default:  res = res;
        endcase
      end
    end
  end

  always_comb begin
    carry_o = 1'b0;
    if (amt_i != '0) begin
      case (mode_i)
        MODE_ROL: carry_o = res[0];
        MODE_ROR: carry_o = res[WIDTH-1];
        MODE_SHL: carry_o = data_i[neg_amt];
        MODE_SHR: carry_o = data_i[dec_amt];
        MODE_SAR: carry_o = data_i[dec_amt];
        default:  carry_o = 1'b0;
      endcase
    end
  end

  assign res_o     = res;
  assign illegal_o = !mode_is_legal(mode_i);

endmodule

// File: rtl/alu_rotator_pipe.sv
// Two-stage valid/ready pipeline around the barrel core: stage 1 captures the
// operation, stage 2 registers the result and flags.
module alu_rotator_pipe
  import alu_rot_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic [MODE_W-1:0] in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_carry,
  output logic              out_zero,
  output logic              out_illegal
);

  logic              s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]  s1_data_q,  s1_data_d;
  logic [AMT_W-1:0]  s1_amt_q,   s1_amt_d;
  logic [MODE_W-1:0] s1_mode_q,  s1_mode_d;

  logic              out_valid_q,   out_valid_d;
  logic [WIDTH-1:0]  out_data_q,    out_data_d;
  logic              out_carry_q,   out_carry_d;
  logic              out_zero_q,    out_zero_d;
  logic              out_illegal_q, out_illegal_d;

  logic             s2_en;
  logic             accept;
  logic [WIDTH-1:0] core_res;
  logic             core_carry;
  logic             core_illegal;

  rot_barrel_core #(.WIDTH(WIDTH)) u_core (
    .data_i    (s1_data_q),
    .amt_i     (s1_amt_q),
    .mode_i    (s1_mode_q),
    .res_o     (core_res),
    .carry_o   (core_carry),
    .illegal_o (core_illegal)
  );

  // Stage 2 advances whenever it is empty or being drained; stage 1 follows.
  assign s2_en    = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_en;
  assign accept   = in_valid && in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_amt_d   = s1_amt_q;
    s1_mode_d  = s1_mode_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_data_d  = in_data;
      s1_amt_d   = in_amt;
      s1_mode_d  = in_mode;
    end else if (s2_en) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_carry_d   = out_carry_q;
    out_zero_d    = out_zero_q;
    out_illegal_d = out_illegal_q;
    if (s2_en) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d    = core_res;
        out_carry_d   = core_carry;
        out_zero_d    = (core_res == '0);
        out_illegal_d = core_illegal;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_data_q     <= '0;
      s1_amt_q      <= '0;
      s1_mode_q     <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_carry_q   <= 1'b0;
      out_zero_q    <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_data_q     <= s1_data_d;
      s1_amt_q      <= s1_amt_d;
      s1_mode_q     <= s1_mode_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_carry_q   <= out_carry_d;
      out_zero_q    <= out_zero_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_carry   = out_carry_q;
  assign out_zero    = out_zero_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_alu_rotator_pipe.sv
// Directed and randomized bench for alu_rotator_pipe (WIDTH=8) with a
// bit-level reference model and an in-order result scoreboard.
module tb_alu_rotator_pipe;

  localparam int W  = 8;
  localparam int AW = 3;

  typedef struct {
    logic [W-1:0] data;
    logic         carry;
    logic         zero;
    logic         ill;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [AW-1:0] in_amt = '0;
  logic [2:0]    in_mode = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic          out_carry;
  logic          out_zero;
  logic          out_illegal;

  int checks = 0;
  int errors = 0;
  int n_acc = 0;
  int n_take = 0;
  int n_drop = 0;
  exp_t q[$];

  alu_rotator_pipe #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_amt      (in_amt),
    .in_mode     (in_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_carry   (out_carry),
    .out_zero    (out_zero),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t ref_model(input logic [W-1:0] d, input int a, input int m);
    exp_t e;
    e.data  = d;
    e.carry = 1'b0;
    e.ill   = 1'b0;
    case (m)
      0: begin
        for (int i = 0; i < W; i++) e.data[(i + a) % W] = d[i];
        if (a != 0) e.carry = e.data[0];
      end
      1: begin
        for (int i = 0; i < W; i++) e.data[i] = d[(i + a) % W];
        if (a != 0) e.carry = e.data[W-1];
      end
      2: begin
        for (int i = 0; i < W; i++) e.data[i] = (i >= a) ? d[i-a] : 1'b0;
        if (a != 0) e.carry = d[W-a];
      end
      3, 4: begin
        for (int i = 0; i < W; i++)
          e.data[i] = (i + a < W) ? d[i+a] : ((m == 4) ? d[W-1] : 1'b0);
        if (a != 0) e.carry = d[a-1];
      end
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.data == '0);
    return e;
  endfunction

  // Scoreboard: handshakes are observed mid-cycle, ahead of the edge that completes them.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) begin
        q.push_back(ref_model(in_data, int'(in_amt), int'(in_mode)));
        n_acc++;
      end
      if (out_valid && out_ready) begin
        n_take++;
        if (q.size() == 0) begin
          chk("sb_spurious", 32'(out_valid), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_data",  32'(out_data),    32'(e.data));
          chk("sb_carry", 32'(out_carry),   32'(e.carry));
          chk("sb_zero",  32'(out_zero),    32'(e.zero));
          chk("sb_ill",   32'(out_illegal), 32'(e.ill));
        end
      end
    end
  end

  task automatic directed(input string tag, input logic [W-1:0] d, input int a, input int m,
                          input logic [W-1:0] ed, input logic ec, input logic ez, input logic ei);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_amt = AW'(a); in_mode = 3'(m);
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_vld"},   32'(out_valid),   32'd1);
    chk({tag, "_data"},  32'(out_data),    32'(ed));
    chk({tag, "_carry"}, 32'(out_carry),   32'(ec));
    chk({tag, "_zero"},  32'(out_zero),    32'(ez));
    chk({tag, "_ill"},   32'(out_illegal), 32'(ei));
  endtask

  // Hold an op on in_* until it is accepted, within a cycle budget.
  task automatic offer(input logic [W-1:0] d, input int a, input int m);
    bit done = 0;
    in_valid = 1'b1; in_data = d; in_amt = AW'(a); in_mode = 3'(m);
    for (int t = 0; t < 1000 && !done; t++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) chk("offer_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  bit rnd_run;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld",   32'(out_valid),   32'd0);
    chk("rst_data",  32'(out_data),    32'd0);
    chk("rst_carry", 32'(out_carry),   32'd0);
    chk("rst_zero",  32'(out_zero),    32'd0);
    chk("rst_ill",   32'(out_illegal), 32'd0);
    rst = 1'b0;
    #0;
    chk("rst_rdy", 32'(in_ready), 32'd1);

    directed("rol3",  8'hB4, 3, 0, 8'hA5, 1'b1, 1'b0, 1'b0);
    directed("ror1",  8'hB4, 1, 1, 8'h5A, 1'b0, 1'b0, 1'b0);
    directed("shl1",  8'h81, 1, 2, 8'h02, 1'b1, 1'b0, 1'b0);
    directed("sar2",  8'h90, 2, 4, 8'hE4, 1'b0, 1'b0, 1'b0);
    directed("shr1",  8'h01, 1, 3, 8'h00, 1'b1, 1'b1, 1'b0);
    directed("res6",  8'h3C, 5, 6, 8'h3C, 1'b0, 1'b0, 1'b1);
    directed("rol0",  8'h5A, 0, 0, 8'h5A, 1'b0, 1'b0, 1'b0);
    directed("shl7",  8'h03, 7, 2, 8'h80, 1'b1, 1'b0, 1'b0);
    directed("shr7",  8'h80, 7, 3, 8'h01, 1'b0, 1'b0, 1'b0);
    directed("sar7",  8'h80, 7, 4, 8'hFF, 1'b0, 1'b0, 1'b0);
    directed("ror7",  8'h01, 7, 1, 8'h02, 1'b0, 1'b0, 1'b0);
    directed("res7z", 8'h00, 2, 7, 8'h00, 1'b0, 1'b1, 1'b1);
    drain();

    // Back-to-back: five consecutive accepts, five consecutive results.
    @(posedge clk); #1;
    for (int c = 0; c < 8; c++) begin
      if (c < 5) begin
        in_valid = 1'b1; in_data = 8'(8'h11 * (c + 1)); in_amt = AW'(c); in_mode = 3'(c);
      end else begin
        in_valid = 1'b0;
      end
      if (c >= 1) chk("b2b_vld", 32'(out_valid), 32'((c >= 2 && c <= 6) ? 1 : 0));
      @(negedge clk);
      if (c < 5) chk("b2b_rdy", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    drain();

    // Backpressure: consumer stalls for 4 cycles while 3 ops are offered.
    out_ready = 1'b0;
    offer(8'hC3, 2, 0);
    offer(8'h96, 3, 1);
    in_valid = 1'b1; in_data = 8'h7E; in_amt = 3'd1; in_mode = 3'd4;
    for (int c = 0; c < 2; c++) begin
      chk("bp_hold_vld",  32'(out_valid), 32'd1);
      chk("bp_hold_data", 32'(out_data),  32'h0F);
      @(negedge clk);
      chk("bp_rdy_low", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    offer(8'h7E, 1, 4);
    drain();
    chk("bp_counts", 32'(n_take), 32'(n_acc));

    // Reset with two ops in flight.
    out_ready = 1'b0;
    offer(8'hF0, 4, 2);
    offer(8'h0F, 4, 3);
    chk("pre_rst_vld", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_drop += q.size();
    q.delete();
    chk("mid_rst_vld",   32'(out_valid),   32'd0);
    chk("mid_rst_rdy",   32'(in_ready),    32'd1);
    chk("mid_rst_data",  32'(out_data),    32'd0);
    chk("mid_rst_carry", 32'(out_carry),   32'd0);
    chk("mid_rst_zero",  32'(out_zero),    32'd0);
    chk("mid_rst_ill",   32'(out_illegal), 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("post_rst_idle", 32'(out_valid), 32'd0);
    end

    // Random traffic with random backpressure.
    rnd_run = 1'b1;
    fork
      begin
        while (rnd_run) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
      begin
        for (int n = 0; n < 10000; n++) begin
          if ($urandom_range(0, 4) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
          end
          offer(8'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end
        rnd_run = 1'b0;
      end
    join
    drain();
    chk("final_counts", 32'(n_acc), 32'(n_take + n_drop));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
